// File: rtl/pos_maxterm_extractor_pkg.sv
// Shared types and sizing for the maxterm extractor: FSM states and truth-table geometry.
package pos_maxterm_extractor_pkg;

    localparam int unsigned N_VARS = 3;
    localparam int unsigned ROWS   = 1 << N_VARS;
    localparam int unsigned CNT_W  = N_VARS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pos_maxterm_extractor_if.sv
// Maxterm output stream: valid/ready handshake carrying row index and literal polarity.
interface pos_maxterm_extractor_if;
    import pos_maxterm_extractor_pkg::*;

    logic              out_valid;
    logic              out_ready;
    logic [N_VARS-1:0] out_index;
    logic [N_VARS-1:0] out_neg;

    modport master (output out_valid, output out_index, output out_neg, input out_ready);
    modport slave  (input out_valid, input out_index, input out_neg, output out_ready);

endinterface

// File: rtl/pos_maxterm_extractor_row_scanner.sv
// Captured truth table plus row counter; exposes the current row's bit and a last-row flag.
module pos_row_scanner
    import pos_maxterm_extractor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [ROWS-1:0]   tt_i,
    output logic [N_VARS-1:0] idx_o,
    output logic              row_bit_o,
    output logic              last_o
);

    logic [ROWS-1:0]   tt_q;
    logic [N_VARS-1:0] idx_q;

    // Load restarts at row 0; advance is only requested when the row is not the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt_q  <= '0;
            idx_q <= '0;
        end else if (load_i) begin
            tt_q  <= tt_i;
            idx_q <= '0;
        end else if (adv_i) begin
            idx_q <= idx_q + N_VARS'(1);
        end
    end

    assign idx_o     = idx_q;
    assign row_bit_o = tt_q[idx_q];
    assign last_o    = (idx_q == N_VARS'(ROWS - 1));

endmodule

// File: rtl/pos_maxterm_extractor.sv
// Streams the maxterms (zero rows) of a captured truth table over a valid/ready port,
// then reports the maxterm count and constant-function flags with a one-cycle done.
module pos_maxterm_extractor
    import pos_maxterm_extractor_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ROWS-1:0]          tt,
    pos_maxterm_extractor_if.master  out_if,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         count,
    output logic                     const_one,
    output logic                     const_zero
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [N_VARS-1:0] index_q, index_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              const_one_q, const_one_d;
    logic              const_zero_q, const_zero_d;

    logic              load, adv;
    logic [N_VARS-1:0] row_idx;
    logic              row_bit, row_last;

    pos_row_scanner u_scanner (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .adv_i     (adv),
        .tt_i      (tt),
        .idx_o     (row_idx),
        .row_bit_o (row_bit),
        .last_o    (row_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            run_cnt_q    <= '0;
            count_q      <= '0;
            index_q      <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            const_one_q  <= 1'b0;
            const_zero_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            count_q      <= count_d;
            index_q      <= index_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            const_one_q  <= const_one_d;
            const_zero_q <= const_zero_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        count_d      = count_q;
        index_d      = index_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        const_one_d  = const_one_q;
        const_zero_d = const_zero_q;
        load         = 1'b0;
        adv          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    run_cnt_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!row_bit) begin
                    index_d = row_idx;
                    valid_d = 1'b1;
                    state_d = EMIT;
                end else if (row_last) begin
                    state_d = DONE;
                end else begin
                    adv = 1'b1;
                end
            end
            EMIT: begin
                // Last-row test precedes the increment so the row counter never wraps.
                if (out_if.out_ready) begin
                    valid_d   = 1'b0;
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                    if (row_last) begin
                        state_d = DONE;
                    end else begin
                        adv     = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                done_d       = 1'b1;
                count_d      = run_cnt_q;
                const_one_d  = (run_cnt_q == '0);
                const_zero_d = (run_cnt_q == CNT_W'(ROWS));
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SCAN) || (state_d == EMIT);
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_index = index_q;
    assign out_if.out_neg   = index_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign count            = count_q;
    assign const_one        = const_one_q;
    assign const_zero       = const_zero_q;

endmodule

// File: tb/tb_pos_maxterm_extractor.sv
// Bench for pos_maxterm_extractor: directed and random truth tables against a list-of-zero-rows model.
module tb_pos_maxterm_extractor;
    import pos_maxterm_extractor_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROWS-1:0]  tt;
    logic             busy, done, const_one, const_zero;
    logic [CNT_W-1:0] count;

    pos_maxterm_extractor_if bus ();

    pos_maxterm_extractor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .tt         (tt),
        .out_if     (bus),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .const_one  (const_one),
        .const_zero (const_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int got[$];
    int lat;
    bit timed_out;
    int hold_err;
    int neg_err;
    logic busy_first;
    logic done_after;

    // Reference: maxterms are exactly the rows whose truth-table bit is 0, in ascending order.
    function void build_exp(input logic [ROWS-1:0] t);
        exp_q.delete();
        for (int i = 0; i < ROWS; i++)
            if (t[i] == 1'b0) exp_q.push_back(i);
    endfunction

    // Drives one scan and records emitted maxterms, latency and hold-stability observations.
    task automatic run_scan(input logic [ROWS-1:0] tt_v, input int stall, input bit restart);
        int  stall_left;
        bit  pending;
        int  held;
        got.delete();
        lat = 0; timed_out = 1; hold_err = 0; neg_err = 0;
        pending = 0; stall_left = 0; held = 0;
        tt = tt_v; start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_first = busy;
        for (int n = 1; n < 400; n++) begin
            if (bus.out_valid) begin
                if (!pending) begin
                    pending = 1; held = int'(bus.out_index); stall_left = stall;
                end else if (int'(bus.out_index) != held) begin
                    hold_err++;
                end
                if (bus.out_neg !== bus.out_index) neg_err++;
            end else if (pending) begin
                hold_err++;
            end
            if (bus.out_valid && stall_left > 0) begin
                bus.out_ready = 1'b0; stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(int'(bus.out_index)); pending = 0;
            end
            if (restart && n == 3) begin
                start = 1'b1; tt = ~tt_v;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                lat = n + 1; timed_out = 0;
                break;
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tt = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_index !== '0 || bus.out_neg !== '0) begin
            errors++;
            $display("FAIL reset_stream: valid=%b index=%0d neg=%b, required 0/0/000", bus.out_valid, bus.out_index, bus.out_neg);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || count !== '0 || const_one !== 1'b0 || const_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b count=%0d c1=%b c0=%b, required all 0", busy, done, count, const_one, const_zero);
        end
        rst = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_5a();
        run_scan(8'h5A, 0, 0);
        build_exp(8'h5A);
        checks++;
        if (timed_out || got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count_seen: got %0d maxterms (timeout=%0b), required %0d", got.size(), timed_out, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got[i] != exp_q[i]) begin
                    errors++;
                    $display("FAIL basic_index[%0d]: got %0d, required %0d", i, got[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (neg_err != 0) begin
            errors++;
            $display("FAIL basic_neg: %0d cycles with out_neg != out_index, required 0", neg_err);
        end
        checks++;
        if (count !== CNT_W'(4) || const_one !== 1'b0 || const_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_summary: count=%0d c1=%b c0=%b, required 4/0/0", count, const_one, const_zero);
        end
        checks++;
        if (lat != 2 + ROWS + 4) begin
            errors++;
            $display("FAIL basic_latency: done in cycle %0d, required %0d", lat, 2 + ROWS + 4);
        end
        checks++;
        if (busy_first !== 1'b1 || done_after !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: busy_first=%b done_after=%b busy_end=%b, required 1/0/0", busy_first, done_after, busy);
        end
    endtask

    task automatic test_all_ones();
        run_scan(8'hFF, 0, 0);
        checks++;
        if (timed_out || got.size() != 0) begin
            errors++;
            $display("FAIL ones_stream: got %0d maxterms (timeout=%0b), required 0", got.size(), timed_out);
        end
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL ones_latency: done in cycle %0d, required 10", lat);
        end
        checks++;
        if (count !== '0 || const_one !== 1'b1 || const_zero !== 1'b0) begin
            errors++;
            $display("FAIL ones_summary: count=%0d c1=%b c0=%b, required 0/1/0", count, const_one, const_zero);
        end
    endtask

    task automatic test_all_zeros();
        run_scan(8'h00, 0, 0);
        checks++;
        if (timed_out || got.size() != ROWS) begin
            errors++;
            $display("FAIL zeros_stream: got %0d maxterms (timeout=%0b), required %0d", got.size(), timed_out, ROWS);
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                checks++;
                if (got[i] != i) begin
                    errors++;
                    $display("FAIL zeros_index[%0d]: got %0d, required %0d", i, got[i], i);
                end
            end
        end
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL zeros_latency: done in cycle %0d, required 18", lat);
        end
        checks++;
        if (count !== CNT_W'(ROWS) || const_one !== 1'b0 || const_zero !== 1'b1) begin
            errors++;
            $display("FAIL zeros_summary: count=%0d c1=%b c0=%b, required %0d/0/1", count, const_one, const_zero, ROWS);
        end
    endtask

    task automatic test_stall();
        run_scan(8'h5A, 3, 0);
        build_exp(8'h5A);
        checks++;
        if (timed_out || got != exp_q) begin
            errors++;
            $display("FAIL stall_sequence: got %p (timeout=%0b), required %p", got, timed_out, exp_q);
        end
        checks++;
        if (hold_err != 0 || neg_err != 0) begin
            errors++;
            $display("FAIL stall_hold: hold_err=%0d neg_err=%0d, required 0/0", hold_err, neg_err);
        end
        checks++;
        if (lat != 2 + ROWS + 4 + 3 * 4) begin
            errors++;
            $display("FAIL stall_latency: done in cycle %0d, required %0d", lat, 2 + ROWS + 16);
        end
        checks++;
        if (count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL stall_count: count=%0d, required 4", count);
        end
    endtask

    task automatic test_restart_ignored();
        run_scan(8'h5A, 0, 1);
        build_exp(8'h5A);
        checks++;
        if (timed_out || got != exp_q) begin
            errors++;
            $display("FAIL restart_sequence: got %p (timeout=%0b), required %p", got, timed_out, exp_q);
        end
        checks++;
        if (count !== CNT_W'(4)) begin
            errors++;
            $display("FAIL restart_count: count=%0d, required 4", count);
        end
    endtask

    task automatic test_reset_mid_scan();
        int  hs;
        bit  seen_done;
        hs = 0; seen_done = 0;
        tt = 8'h5A; start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (bus.out_valid && bus.out_ready) hs++;
            @(posedge clk); #1;
            if (hs == 2) break;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (hs != 2 || bus.out_valid !== 1'b0 || busy !== 1'b0 || count !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: hs=%0d valid=%b busy=%b count=%0d done=%b, required 2/0/0/0/0", hs, bus.out_valid, busy, count, done);
        end
        for (int n = 0; n < 20; n++) begin
            if (done === 1'b1 || bus.out_valid === 1'b1) seen_done = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL midreset_quiet: done or out_valid seen after abort, required none");
        end
        run_scan(8'hFF, 0, 0);
        checks++;
        if (timed_out || lat != 10 || count !== '0 || const_one !== 1'b1) begin
            errors++;
            $display("FAIL midreset_rescan: lat=%0d timeout=%0b count=%0d c1=%b, required 10/0/0/1", lat, timed_out, count, const_one);
        end
    endtask

    task automatic test_random();
        logic [ROWS-1:0] t;
        int              st;
        int              m;
        for (int k = 0; k < 8; k++) begin
            t  = ROWS'($urandom);
            st = int'($urandom_range(0, 2));
            build_exp(t);
            m = exp_q.size();
            run_scan(t, st, 0);
            checks++;
            if (timed_out || got != exp_q) begin
                errors++;
                $display("FAIL random_sequence tt=%h: got %p (timeout=%0b), required %p", t, got, timed_out, exp_q);
            end
            checks++;
            if (count !== CNT_W'(m) || const_one !== (m == 0) || const_zero !== (m == ROWS)) begin
                errors++;
                $display("FAIL random_summary tt=%h: count=%0d c1=%b c0=%b, required %0d/%0b/%0b", t, count, const_one, const_zero, m, m == 0, m == ROWS);
            end
            checks++;
            if (lat != 2 + ROWS + m + st * m || hold_err != 0 || neg_err != 0) begin
                errors++;
                $display("FAIL random_timing tt=%h stall=%0d: lat=%0d hold_err=%0d neg_err=%0d, required lat %0d, 0, 0", t, st, lat, hold_err, neg_err, 2 + ROWS + m + st * m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_5a();
        test_all_ones();
        test_all_zeros();
        test_stall();
        test_restart_ignored();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_maxterm_extractor.md
Name: pos_maxterm_extractor

Overview:
- Inverse of the team's PoS evaluator blocks: takes a truth table for an N-variable function and streams out the function's maxterms (rows where f=0) one at a time.
- Each emitted maxterm carries its row index and literal polarity, so downstream logic or a bench can rebuild the canonical product of sums.
- Sits between a truth-table source (bench or configuration register) and a PoS checker or display stage.
- Output uses a valid/ready handshake.

Parameters:
- N_VARS, 3, number of input variables; truth table has 2**N_VARS rows; row i = {x,y,z,...} with MSB = first variable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- tt  in  2**N_VARS  truth table; bit i = f(row i); captured on accepted start.
- busy  out  1  high in SCAN/EMIT.
- out_valid  out  1  maxterm presented.
- out_ready  in  1  consumer accepts the maxterm when out_valid && out_ready.
- out_index  out  N_VARS  row index of the current maxterm.
- out_neg  out  N_VARS  literal polarity per variable. 1 = complemented literal (~v), 0 = true literal (v). Equals out_index.
- done  out  1  one-cycle pulse at end of scan.
- count  out  N_VARS+1  number of maxterms emitted in the last completed scan.
- const_one  out  1  valid with done: tt all ones, so no maxterms and f=1.
- const_zero  out  1  valid with done: tt all zeros, so every row is a maxterm and f=0.

Behaviour:
- Reset:
  - state=IDLE; idx=0.
  - out_valid=0, out_index=0, out_neg=0.
  - busy=0, done=0, count=0, const_one=0, const_zero=0.
  - Reset asserted mid-scan aborts the scan immediately. No done pulse. count is cleared.
- IDLE:
  - start=1 → tt_q<=tt, idx<=0, run_cnt<=0, state<=SCAN.
  - tt changes outside an accepted start are ignored.
- SCAN (one row per cycle):
  - tt_q[idx]==0 → out_index<=idx, out_valid<=1, state<=EMIT.
  - Otherwise, if idx==2**N_VARS-1 → state<=DONE; else idx<=idx+1.
- EMIT:
  - out_valid, out_index and out_neg are held stable until out_ready.
  - On handshake: out_valid<=0, run_cnt<=run_cnt+1; then state<=DONE if idx is the last row, else idx<=idx+1 and state<=SCAN.
  - out_ready already high when EMIT is entered → handshake occurs in that first EMIT cycle, so each maxterm costs exactly 2 cycles.
- DONE (one cycle):
  - done=1, count<=run_cnt (final value including the last handshake).
  - const_one=(run_cnt==0); const_zero=(run_cnt==2**N_VARS).
  - state<=IDLE.
  - count, const_one and const_zero hold until the next done or reset.
- start while busy or in DONE: ignored, no queuing.
- Latency with out_ready tied high: done asserts 1 + 2**N_VARS + (#maxterms) + 1 cycles after the edge that samples start.
  - N_VARS=3, tt=8'hFF → done in the 10th cycle after start.
- Index counter does not wrap: the last-row check happens before increment. count width N_VARS+1 holds the value 2**N_VARS.
- busy and out_valid are purely registered outputs; there is no combinational path from out_ready to out_valid.

Decomposition:
- Shared package:
  - state enum {IDLE, SCAN, EMIT, DONE}.
  - localparam ROWS = 2**N_VARS.
- Sub-module: pos_row_scanner, the idx counter with last-row detect and the tt_q bit select. The FSM and handshake live in the top level.

Test Plan:
- tt=8'h5A (x^z, i.e. (x|z)&(~x|~z)), out_ready=1 → maxterms 0,2,5,7 in order; out_neg 000,010,101,111; count=4; const_one=0, const_zero=0.
- tt=8'hFF → no out_valid; done 10 cycles after start; count=0; const_one=1.
- tt=8'h00, out_ready=1 → indices 0..7; count=8; const_zero=1; done 18 cycles after start.
- tt=8'h5A, out_ready low for 3 cycles at each maxterm → out_valid, out_index and out_neg held stable during each stall; same 4 maxterms, no loss or duplication.
- Pulse rst in the cycle after the second maxterm handshake of tt=8'h5A → next cycle: out_valid=0, busy=0, count=0, no done; a new start with tt=8'hFF then completes normally.
- start pulsed again mid-scan with a different tt → ignored; the original scan's maxterm sequence and count are unchanged.
